// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe divider, h/v raster counters,
// registered sync/data-enable decode, line/frame start pulses and a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic               pix_stb_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic [X_W-1:0]     x_o,
  output logic [Y_W-1:0]     y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_VIS    = H_ACTIVE;
  localparam int unsigned V_VIS    = V_ACTIVE;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [DIV_W-1:0] div;
  logic [X_W-1:0]   h;
  logic [Y_W-1:0]   v;
  logic             tick;
  logic [31:0]      h_ext;
  logic [31:0]      v_ext;
  logic             de_n;
  logic             hs_n;
  logic             vs_n;

  // Decode is widened to 32 bits so sync window ends equal to H_TOTAL cannot overflow X_W.
  always_comb begin
    tick  = en_i && (div == DIV_LAST);
    h_ext = 32'(h);
    v_ext = 32'(v);
    de_n  = (h_ext < H_VIS) && (v_ext < V_VIS);
    hs_n  = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_n  = (v_ext >= VS_START) && (v_ext < VS_END);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div           <= '0;
      h             <= '0;
      v             <= '0;
      pix_stb_o     <= 1'b0;
      hsync_o       <= ~HS_ON;
      vsync_o       <= ~VS_ON;
      de_o          <= 1'b0;
      x_o           <= '0;
      y_o           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      pix_stb_o     <= tick;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (en_i) begin
        div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
      // Outputs show the pre-advance pixel so they appear together with pix_stb_o.
      if (tick) begin
        x_o          <= h;
        y_o          <= v;
        de_o         <= de_n;
        hsync_o      <= hs_n ? HS_ON : ~HS_ON;
        vsync_o      <= vs_n ? VS_ON : ~VS_ON;
        line_start_o <= (h == '0);
        if ((h == '0) && (v == '0)) begin
          frame_start_o <= 1'b1;
          frame_cnt_o   <= frame_cnt_o + 1'b1;
        end
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on an 8x6 raster: divided strobe with active-low
// syncs (dut_a) and undivided strobe with active-high syncs (dut_b).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic       stb_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;
  logic       stb_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [7:0] fc_b;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .X_W(10), .Y_W(10), .FRAME_W(8)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en_a), .pix_stb_o(stb_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a), .x_o(x_a), .y_o(y_a),
    .line_start_o(ls_a), .frame_start_o(fs_a), .frame_cnt_o(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(1), .X_W(10), .Y_W(10), .FRAME_W(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en_b), .pix_stb_o(stb_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .x_o(x_b), .y_o(y_b),
    .line_start_o(ls_b), .frame_start_o(fs_b), .frame_cnt_o(fc_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    int q, ex, ey, p;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stb", int'(stb_a), 0);
    chk("rst_hs", int'(hs_a), 1);
    chk("rst_vs", int'(vs_a), 1);
    chk("rst_de", int'(de_a), 0);
    chk("rst_x", int'(x_a), 0);
    chk("rst_y", int'(y_a), 0);
    chk("rst_fc", int'(fc_a), 0);
    chk("rst_ls", int'(ls_a), 0);
    chk("rst_hs_b", int'(hs_b), 0);
    chk("rst_vs_b", int'(vs_b), 0);

    rst = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;

    // n counts clock edges since release; raster is 8 px x 6 lines = 48 px/frame.
    for (int n = 1; n <= 311; n++) begin
      @(negedge clk);
      chk("a_stb", int'(stb_a), (n % 2 == 0) ? 1 : 0);
      if (n % 2 == 1) begin
        chk("a_ls_idle", int'(ls_a), 0);
        chk("a_fs_idle", int'(fs_a), 0);
      end
      if (n == 1) begin
        chk("a_x_pre", int'(x_a), 0);
        chk("a_de_pre", int'(de_a), 0);
        chk("a_fc_pre", int'(fc_a), 0);
      end else begin
        q  = n / 2 - 1;
        ex = q % 8;
        ey = (q / 8) % 6;
        chk("a_x", int'(x_a), ex);
        chk("a_y", int'(y_a), ey);
        chk("a_de", int'(de_a), (ex < 4 && ey < 3) ? 1 : 0);
        chk("a_hs", int'(hs_a), (ex == 5 || ex == 6) ? 0 : 1);
        chk("a_vs", int'(vs_a), (ey == 4) ? 0 : 1);
        chk("a_fc", int'(fc_a), (q / 48 + 1) % 256);
        if (n % 2 == 0) begin
          chk("a_ls", int'(ls_a), (ex == 0) ? 1 : 0);
          chk("a_fs", int'(fs_a), (q % 48 == 0) ? 1 : 0);
        end
      end
      p  = n - 1;
      ex = p % 8;
      ey = (p / 8) % 6;
      chk("b_stb", int'(stb_b), 1);
      chk("b_x", int'(x_b), ex);
      chk("b_y", int'(y_b), ey);
      chk("b_hs", int'(hs_b), (ex == 5 || ex == 6) ? 1 : 0);
      chk("b_vs", int'(vs_b), (ey == 4) ? 1 : 0);
      chk("b_ls", int'(ls_b), (ex == 0) ? 1 : 0);
      chk("b_fs", int'(fs_b), (p % 48 == 0) ? 1 : 0);
      chk("b_fc", int'(fc_b), (p / 48 + 1) % 256);
    end

    // Divider is mid-count here (pixel 154 shown: x=2, y=1); freeze for 5 cycles.
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("frz_stb", int'(stb_a), 0);
      chk("frz_x", int'(x_a), 2);
      chk("frz_y", int'(y_a), 1);
      chk("frz_de", int'(de_a), 1);
      chk("frz_ls", int'(ls_a), 0);
      chk("frz_hs", int'(hs_a), 1);
    end
    en_a = 1'b1;
    @(negedge clk);
    chk("resume_stb", int'(stb_a), 1);
    chk("resume_x", int'(x_a), 3);
    chk("resume_y", int'(y_a), 1);

    // Advance 22 pixels to pixel 177 = frame 4, x=1, y=4 (vsync active).
    for (int k = 0; k < 44; k++) @(negedge clk);
    chk("pre_rst_y", int'(y_a), 4);
    chk("pre_rst_x", int'(x_a), 1);
    chk("pre_rst_vs", int'(vs_a), 0);
    chk("pre_rst_fc", int'(fc_a), 4);

    #2 rst = 1'b1;
    #1;
    chk("arst_vs", int'(vs_a), 1);
    chk("arst_x", int'(x_a), 0);
    chk("arst_y", int'(y_a), 0);
    chk("arst_de", int'(de_a), 0);
    chk("arst_fc", int'(fc_a), 0);
    chk("arst_stb", int'(stb_a), 0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_stb0", int'(stb_a), 0);
    @(negedge clk);
    chk("rel_stb1", int'(stb_a), 1);
    chk("rel_x", int'(x_a), 0);
    chk("rel_y", int'(y_a), 0);
    chk("rel_de", int'(de_a), 1);
    chk("rel_fs", int'(fs_a), 1);
    chk("rel_ls", int'(ls_a), 1);
    chk("rel_fc", int'(fc_a), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for board_top; replaces the fixed 640x480 sync logic.
- Derives a pixel strobe from clk_i by an integer divider; CLK_DIV=2 gives 25 MHz pixels from the 50 MHz board clock.
- Outputs sync pulses of configurable polarity, data-enable, pixel coordinates, line/frame start pulses and a frame counter.
- Game logic and the pixel pipeline consume the coordinates and the pixel strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CLK_DIV, 2, clk_i cycles per pixel (>=1)
- X_W, 10, width of x_o (>= clog2(H_TOTAL))
- Y_W, 10, width of y_o (>= clog2(V_TOTAL))
- FRAME_W, 8, width of frame_cnt_o

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  run enable; 0 freezes the generator
- pix_stb_o  out  1  one-cycle pixel strobe; all other outputs change only on cycles with pix_stb_o=1
- hsync_o  out  1  horizontal sync, level per HS_POL
- vsync_o  out  1  vertical sync, level per VS_POL
- de_o  out  1  pixel (x_o,y_o) is in the visible area
- x_o  out  X_W  current pixel column, 0..H_TOTAL-1
- y_o  out  Y_W  current line, 0..V_TOTAL-1
- line_start_o  out  1  one-cycle pulse when x_o becomes 0
- frame_start_o  out  1  one-cycle pulse when (x_o,y_o) becomes (0,0)
- frame_cnt_o  out  FRAME_W  completed-frame counter

Behaviour:
- H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
- Divider counter div counts 0..CLK_DIV-1 while en_i=1. pix_stb_o is registered and is 1 in the cycle after div==CLK_DIV-1. With CLK_DIV=1, pix_stb_o=1 every enabled cycle.
- Internal counters h and v advance on each strobe:
  - h wraps at H_TOTAL-1 to 0 and increments v.
  - v wraps at V_TOTAL-1 to 0.
- Outputs are registered and are loaded from the decode of the pre-advance (h,v) on the strobe cycle. Outputs therefore show pixel (h,v), and the counters move to the next pixel.
- Decode for a given (h,v):
  - de_o = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync_o is at the active level iff H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync_o is at the active level iff V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, for every h on those lines.
- line_start_o = 1 for the one clk_i cycle in which x_o is loaded with 0; 0 otherwise.
- frame_start_o = 1 for the one clk_i cycle in which (x_o,y_o) is loaded with (0,0).
- frame_cnt_o increments in the same cycle frame_start_o is asserted and wraps modulo 2^FRAME_W. The first frame after reset therefore shows 1.
- Reset values: div=0, h=0, v=0, pix_stb_o=0, de_o=0, x_o=0, y_o=0, line_start_o=0, frame_start_o=0, frame_cnt_o=0, hsync_o=~HS_POL, vsync_o=~VS_POL.
- First strobe after reset release loads pixel (0,0): de_o=1 and line_start_o=frame_start_o=1. The first strobe occurs CLK_DIV cycles after the first enabled edge.
- en_i=0:
  - div, h, v and all level outputs hold.
  - pix_stb_o, line_start_o and frame_start_o are 0.
  - When en_i returns to 1, counting resumes from the held div value with no skipped pixels.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). No partial sync pulse is preserved.
- Sync widths are exact: hsync active for H_SYNC strobes per line, vsync active for V_SYNC*H_TOTAL strobes per frame.

Test Plan:
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=2, HS_POL=VS_POL=0), reset released, en_i=1 -> pix_stb_o every 2nd cycle; first strobe shows x=0, y=0, de=1, line_start=frame_start=1.
- Same config, one line -> de_o=1 for x 0..3; hsync_o=0 exactly for x 5,6; x_o wraps 7->0 with line_start_o=1 and y_o incremented.
- Same config, full frames -> vsync_o=0 for all 8 pixels of y=4 only; frame_start_o every 48 strobes (96 clk_i cycles); frame_cnt_o=1,2,3 on successive frames.
- CLK_DIV=1, HS_POL=VS_POL=1 -> pix_stb_o held high; sync pulses active-high with identical positions and widths.
- en_i=0 for 5 cycles at x=2 -> outputs frozen, no strobes; after re-enable the next strobe shows x=3 with no pixel skipped.
- rst_i asserted at y=4 (vsync active) -> vsync_o goes to 1 and x/y/de_o/frame_cnt_o go to 0 asynchronously; after release the sequence restarts at (0,0).
